tx_burst_sched: RTL and testbench

Sequencer that drives the polyphase BPSK transmit filter: it generates the filter enable, the upsampling phase and symbol-boundary strobe, and a PRBS9 symbol stream. It runs a burst of N symbols, or continuous mode until stopped, then pads the filter tail before releasing. It sits between the test/control logic (start/stop/config) and the transmit filter.

---
 rtl/tx_burst_sched_if.sv | 27 ++
 rtl/tx_burst_sched.sv | 150 +++++++++++++++
 tb/tb_tx_burst_sched.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/tx_burst_sched_if.sv
// Control/status bundle between the burst controller and the transmit-filter sequencer.
interface tx_burst_sched_if #(
   parameter int LEN_BITS   = 16,
   parameter int PHASE_BITS = 2
);
   logic                  start;
   logic                  stop;
   logic [LEN_BITS-1:0]   burst_len;
   logic [8:0]            seed;
   logic                  filt_enable;
   logic                  symbol;
   logic [PHASE_BITS-1:0] phase;
   logic                  sym_strobe;
   logic                  busy;
   logic                  done;
   logic [LEN_BITS-1:0]   sym_count;

   modport master (
      output start, stop, burst_len, seed,
      input  filt_enable, symbol, phase, sym_strobe, busy, done, sym_count
   );

   modport slave (
      input  start, stop, burst_len, seed,
      output filt_enable, symbol, phase, sym_strobe, busy, done, sym_count
   );
endinterface

// File: rtl/tx_burst_sched.sv
// Burst sequencer for the polyphase BPSK transmit filter: enable, phase, symbol strobe,
// PRBS9 symbols, then DEPTH symbols of tail padding before a one-cycle done pulse.
module tx_burst_sched #(
   parameter int   USAMPLE    = 4,
   parameter int   DEPTH      = 6,
   parameter int   LEN_BITS   = 16,
   parameter logic FLUSH_SYM  = 1'b0,
   parameter int   PHASE_BITS = $clog2(USAMPLE)
) (
   input  logic              clk,
   input  logic              rst,
   tx_burst_sched_if.slave   bus
);
   localparam int FC_BITS = (DEPTH < 2) ? 1 : $clog2(DEPTH);
   localparam logic [PHASE_BITS-1:0] PH_LAST = PHASE_BITS'(USAMPLE - 1);
   localparam logic [PHASE_BITS-1:0] PH_ONE  = PHASE_BITS'(1);
   localparam logic [LEN_BITS-1:0]   LEN_ONE = LEN_BITS'(1);
   localparam logic [LEN_BITS-1:0]   LEN_ZERO = LEN_BITS'(0);
   localparam logic [FC_BITS-1:0]    FC_LAST = FC_BITS'(DEPTH - 1);
   localparam logic [FC_BITS-1:0]    FC_ONE  = FC_BITS'(1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FLUSH = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   state_t                state_r;
   logic [8:0]            prbs_r;
   logic                  stop_r;
   logic [LEN_BITS-1:0]   len_r;
   logic [FC_BITS-1:0]    flush_cnt_r;
   logic                  fe_r;
   logic                  symbol_r;
   logic [PHASE_BITS-1:0] phase_r;
   logic                  busy_r;
   logic                  done_r;
   logic [LEN_BITS-1:0]   sym_count_r;
   logic                  strobe_s;
   logic                  end_s;
   logic [8:0]            seed_s;

   function automatic logic [8:0] prbs9_next(input logic [8:0] cur);
      return {cur[7:0], cur[8] ^ cur[4]};
   endfunction

   // Strobe decode, burst-end decision and seed substitution
   always_comb begin
      strobe_s = fe_r & (phase_r == PH_LAST);
      end_s    = 1'b0;
      seed_s   = bus.seed;
      if (strobe_s) begin
         end_s = ((len_r != LEN_ZERO) && ((sym_count_r + LEN_ONE) == len_r)) | stop_r | bus.stop;
      end else begin
         end_s = 1'b0;
      end
      if (bus.seed == 9'd0) begin
         seed_s = 9'h1FF;
      end else begin
         seed_s = bus.seed;
      end
   end

   // Sequencer FSM with all registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= ST_IDLE;
         prbs_r      <= 9'h1FF;
         stop_r      <= 1'b0;
         len_r       <= LEN_ZERO;
         flush_cnt_r <= '0;
         fe_r        <= 1'b0;
         symbol_r    <= 1'b0;
         phase_r     <= '0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
         sym_count_r <= LEN_ZERO;
      end else begin
         done_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (bus.start) begin
                  state_r     <= ST_RUN;
                  prbs_r      <= seed_s;
                  len_r       <= bus.burst_len;
                  sym_count_r <= LEN_ZERO;
                  stop_r      <= 1'b0;
                  fe_r        <= 1'b1;
                  busy_r      <= 1'b1;
                  phase_r     <= '0;
                  symbol_r    <= seed_s[8];
               end
            end
            ST_RUN: begin
               phase_r <= phase_r + PH_ONE;
               if (strobe_s) begin
                  prbs_r      <= prbs9_next(prbs_r);
                  sym_count_r <= sym_count_r + LEN_ONE;
                  if (end_s) begin
                     state_r     <= ST_FLUSH;
                     stop_r      <= 1'b0;
                     flush_cnt_r <= '0;
                     symbol_r    <= FLUSH_SYM;
                  end else begin
                     // Next symbol is the MSB of the shifted register
                     symbol_r <= prbs_r[7];
                  end
               end else if (bus.stop) begin
                  stop_r <= 1'b1;
               end
            end
            ST_FLUSH: begin
               phase_r <= phase_r + PH_ONE;
               if (strobe_s) begin
                  if (flush_cnt_r == FC_LAST) begin
                     state_r  <= ST_DONE;
                     fe_r     <= 1'b0;
                     busy_r   <= 1'b0;
                     done_r   <= 1'b1;
                     phase_r  <= '0;
                     symbol_r <= 1'b0;
                  end else begin
                     flush_cnt_r <= flush_cnt_r + FC_ONE;
                  end
               end
            end
            ST_DONE: begin
               state_r <= ST_IDLE;
            end
            default: begin
               state_r  <= ST_IDLE;
               fe_r     <= 1'b0;
               busy_r   <= 1'b0;
               phase_r  <= '0;
               symbol_r <= 1'b0;
               stop_r   <= 1'b0;
            end
         endcase
      end
   end

   assign bus.filt_enable = fe_r;
   assign bus.symbol      = symbol_r;
   assign bus.phase       = phase_r;
   assign bus.sym_strobe  = strobe_s;
   assign bus.busy        = busy_r;
   assign bus.done        = done_r;
   assign bus.sym_count   = sym_count_r;
endmodule

// File: tb/tb_tx_burst_sched.sv
// Directed bench for tx_burst_sched (USAMPLE=4, DEPTH=6): table of bursts plus reset sequences.
module tb_tx_burst_sched;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;

   tx_burst_sched_if #(.LEN_BITS(16), .PHASE_BITS(2)) bus ();

   tx_burst_sched #(
      .USAMPLE(4), .DEPTH(6), .LEN_BITS(16), .FLUSH_SYM(1'b0)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.slave)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] len;
      logic [8:0]  seed;
      int          stop_cyc;
      int          noise_a;
      int          noise_b;
      logic        stop_with_start;
      int          exp_count;
      int          exp_fe;
      int          exp_done;
      logic [3:0]  exp_syms;
      int          n_syms;
   } vec_t;

   vec_t vecs[6];

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Runs one burst from the table; cycle 0 is the start cycle.
   task automatic run_vec(input int idx, input vec_t v);
      int         cyc;
      int         fe_n;
      int         done_n;
      int         done_cyc;
      int         perr;
      int         cnt_at_done;
      int         k;
      logic       exp_fe_now;
      logic [3:0] s_first;
      logic [3:0] s_last;
      logic [3:0] mask;
      cyc = 0; fe_n = 0; done_n = 0; done_cyc = -1; perr = 0; cnt_at_done = -1;
      s_first = 4'b0000; s_last = 4'b0000;
      bus.start     = 1'b1;
      bus.stop      = v.stop_with_start;
      bus.burst_len = v.len;
      bus.seed      = v.seed;
      while (cyc < 200 && done_cyc < 0) begin
         step();
         cyc++;
         bus.start = (cyc == v.noise_a) || (cyc == v.noise_b);
         bus.stop  = (cyc == v.stop_cyc) || (cyc == v.noise_b);
         exp_fe_now = (cyc >= 1) && (cyc <= v.exp_fe);
         if (bus.filt_enable) fe_n++;
         if (bus.filt_enable !== exp_fe_now) perr++;
         if (bus.busy !== exp_fe_now) perr++;
         if (int'(bus.phase) != (exp_fe_now ? ((cyc - 1) % 4) : 0)) perr++;
         if (bus.sym_strobe !== (exp_fe_now && (cyc % 4 == 0))) perr++;
         if ((cyc > v.exp_count * 4 || !exp_fe_now) && bus.symbol !== 1'b0) perr++;
         if (cyc >= 1 && cyc <= v.exp_count * 4) begin
            k = (cyc + 3) / 4;
            if (k <= 4) begin
               if (cyc % 4 == 1) s_first[4-k] = bus.symbol;
               if (cyc % 4 == 0) s_last[4-k]  = bus.symbol;
            end
         end
         if (bus.done) begin
            done_n++;
            done_cyc    = cyc;
            cnt_at_done = int'(bus.sym_count);
         end
      end
      mask = 4'b1111 << (4 - v.n_syms);
      chk($sformatf("v%0d done_cycle", idx), done_cyc, v.exp_done);
      chk($sformatf("v%0d fe_cycles", idx), fe_n, v.exp_fe);
      chk($sformatf("v%0d sym_count", idx), cnt_at_done, v.exp_count);
      chk($sformatf("v%0d done_pulses", idx), done_n, 1);
      chk($sformatf("v%0d syms_first", idx), int'(s_first & mask), int'(v.exp_syms & mask));
      chk($sformatf("v%0d syms_last", idx), int'(s_last & mask), int'(v.exp_syms & mask));
      chk($sformatf("v%0d cycle_errs", idx), perr, 0);
      step();
      chk($sformatf("v%0d post_done", idx), int'({bus.done, bus.busy, bus.filt_enable}), 0);
      chk($sformatf("v%0d count_hold", idx), int'(bus.sym_count), v.exp_count);
   endtask

   initial begin
      int errs;
      int done_seen;
      vecs[0] = '{16'd3, 9'h1AA, -1, -1, -1, 1'b0, 3, 36, 37, 4'b1100, 3};
      vecs[1] = '{16'd0, 9'h1AA, 18, -1, -1, 1'b0, 5, 44, 45, 4'b1101, 4};
      vecs[2] = '{16'd2, 9'h1AA,  8, -1, -1, 1'b0, 2, 32, 33, 4'b1100, 2};
      vecs[3] = '{16'd4, 9'h000, -1, -1, -1, 1'b0, 4, 40, 41, 4'b1111, 4};
      vecs[4] = '{16'd1, 9'h1AA, -1,  2, 10, 1'b0, 1, 28, 29, 4'b1000, 1};
      vecs[5] = '{16'd2, 9'h000, -1, -1, -1, 1'b1, 2, 32, 33, 4'b1100, 2};

      bus.start = 1'b0; bus.stop = 1'b0; bus.burst_len = 16'd0; bus.seed = 9'd0;
      rst = 1'b1;
      step(); step();
      rst = 1'b0;
      errs = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         if ({bus.filt_enable, bus.symbol, bus.sym_strobe, bus.busy, bus.done} !== 5'b00000) errs++;
         if (bus.phase !== 2'd0 || bus.sym_count !== 16'd0) errs++;
      end
      chk("reset_idle_errs", errs, 0);
      chk("reset_sym_count", int'(bus.sym_count), 0);

      for (int i = 0; i < 6; i++) begin
         run_vec(i, vecs[i]);
      end

      // Reset during the 5th FLUSH cycle of a one-symbol burst
      bus.start = 1'b1; bus.stop = 1'b0; bus.burst_len = 16'd1; bus.seed = 9'h1AA;
      step();
      bus.start = 1'b0;
      for (int c = 2; c <= 9; c++) step();
      chk("pre_rst_in_flush", int'({bus.busy, bus.filt_enable, bus.symbol}), 6);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("rst_fe_busy_done", int'({bus.filt_enable, bus.busy, bus.done, bus.sym_strobe}), 0);
      chk("rst_phase_symbol", int'({bus.phase, bus.symbol}), 0);
      chk("rst_sym_count", int'(bus.sym_count), 0);
      done_seen = 0;
      for (int i = 0; i < 40; i++) begin
         step();
         if (bus.done || bus.filt_enable) done_seen++;
      end
      chk("no_done_after_rst", done_seen, 0);
      run_vec(6, vecs[0]);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
